// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: opcode constants, the NOP encoding and the fetch FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection: pc+4, or pc+imm_ext when a jump or taken branch is signalled.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports: pc, imm_ext, branch, zero, jump in; next_pc, misaligned out.
// Build option FETCH_MISALIGN_TRAP_EN: when defined the raw target is passed through
// and the parent redirects misaligned targets; otherwise target[1:0] is forced to 00.
module next_pc_calc (
    input  logic [31:0] pc,
    input  logic [31:0] imm_ext,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] target;
    logic [31:0] seq_pc;
    logic [31:0] target_sel;
    logic        take;

    // Both additions wrap modulo 2^32 by construction.
    assign target = pc + imm_ext;
    assign seq_pc = pc + 32'd4;
    assign take   = jump | (branch & zero);

    assign misaligned = take & (target[1:0] != 2'b00);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target_sel = target;
`else
    assign target_sel = {target[31:2], 2'b00};
`endif

    assign next_pc = take ? target_sel : seq_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over req/ack, holds the instruction for decode.
// Latency: instr_valid one cycle after the accepting ack; new pc + imem_req one cycle after retire.
// Backpressure: imem_req held with stable address until ack; instruction held while stall or no retire.
//
// Ports: clk, rst (sync, active high); imem_req/imem_addr/imem_ack/imem_rdata to instruction memory;
// instr/op/instr_valid/pc/pc_plus4 to decode; retire/stall/branch/zero/jump/imm_ext from downstream;
// trap pulses on a misaligned control-flow target.
// Build option FETCH_MISALIGN_TRAP_EN: misaligned targets redirect to TRAP_PC and pulse trap;
// when undefined the target is word-aligned, trap is tied low and TRAP_PC is unused.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [6:0]  op,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        retire,
    input  logic        stall,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic [31:0] imm_ext,
    output logic        trap
);

    fetch_state_t state;
    fetch_state_t state_nxt;

    logic        fetch_done;
    logic        advance;
    logic [31:0] next_pc;
    logic        misaligned;
    logic [31:0] pc_sel;

    next_pc_calc u_next_pc_calc (
        .pc         (pc),
        .imm_ext    (imm_ext),
        .branch     (branch),
        .zero       (zero),
        .jump       (jump),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:   if (imem_ack)         state_nxt = EXEC;
            EXEC:    if (retire && !stall) state_nxt = FETCH;
            default:                       state_nxt = FETCH;
        endcase
    end

    // Output logic. The request is masked during reset so that an ack arriving
    // in the reset cycle is never seen as a completed fetch by memory or decode.
    always_comb begin
        imem_req   = (state == FETCH) & ~rst;
        fetch_done = imem_req & imem_ack;
        advance    = (state == EXEC) & retire & ~stall;
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic trap_q;

    assign pc_sel = misaligned ? TRAP_PC : next_pc;
    assign trap   = trap_q;
`else
    logic unused_ok;

    assign pc_sel    = next_pc;
    assign trap      = 1'b0;
    assign unused_ok = ^{TRAP_PC, misaligned};
`endif

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            instr       <= NOP;
            instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            trap_q      <= 1'b0;
`endif
        end else begin
`ifdef FETCH_MISALIGN_TRAP_EN
            // Set on the redirecting retire so it is high for the first FETCH cycle only.
            trap_q <= advance & misaligned;
`endif
            if (fetch_done) begin
                instr       <= imem_rdata;
                instr_valid <= 1'b1;
            end
            if (advance) begin
                pc          <= pc_sel;
                instr_valid <= 1'b0;
            end
        end
    end

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign op        = instr[6:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed fetch/retire sequences with hand-computed addresses.
// Latency: n/a.
// Backpressure: memory ack delays and stall cycles are driven from the stimulus tables.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [6:0]  op;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        retire;
    logic        stall;
    logic        branch;
    logic        zero;
    logic        jump;
    logic [31:0] imm_ext;
    logic        trap;

    typedef struct packed {
        logic [31:0] word;
        logic [6:0]  opc;
    } exp_dec_t;

    logic [31:0] exp_addr_q[$];
    exp_dec_t    exp_dec_q[$];

    int n_pass;
    int n_total;
    int trap_cnt;
    logic prev_valid;

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic [31:0] MIS_ADDR  = 32'h0000_0100;
    localparam int          EXP_TRAPS = 1;
`else
    localparam logic [31:0] MIS_ADDR  = 32'h0000_0020;
    localparam int          EXP_TRAPS = 0;
`endif

    localparam logic [31:0] W_LOAD  = 32'h0000_2083;
    localparam logic [31:0] W_STORE = 32'h0011_2023;
    localparam logic [31:0] W_ADD   = 32'h0020_81B3;
    localparam logic [31:0] W_BEQ   = 32'h0020_8463;
    localparam logic [31:0] W_JAL   = 32'h0080_006F;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .op          (op),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .retire      (retire),
        .stall       (stall),
        .branch      (branch),
        .zero        (zero),
        .jump        (jump),
        .imm_ext     (imm_ext),
        .trap        (trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares accepted fetches and newly valid instructions against the scoreboard.
    always @(negedge clk) begin
        if (imem_req === 1'b1 && imem_ack === 1'b1) begin
            if (exp_addr_q.size() == 0) begin
                n_total++;
                $display("FAIL fetch_addr: unexpected fetch at %h", imem_addr);
            end else begin
                chk("fetch_addr", imem_addr, exp_addr_q.pop_front());
            end
        end
        if (instr_valid === 1'b1 && prev_valid !== 1'b1) begin
            if (exp_dec_q.size() == 0) begin
                n_total++;
                $display("FAIL decode: unexpected instr %h", instr);
            end else begin
                exp_dec_t e;
                e = exp_dec_q.pop_front();
                chk("instr", instr, e.word);
                chk("op", {25'd0, op}, {25'd0, e.opc});
            end
        end
        if (trap === 1'b1) begin
            trap_cnt++;
            chk("trap_fetch_addr", imem_addr, MIS_ADDR);
        end
        prev_valid = instr_valid;
    end

    // Caller is 1 time unit after a rising edge with the DUT in FETCH.
    task automatic fetch_instr(input logic [31:0] addr, input int delay,
                               input logic [31:0] word, input logic [6:0] exp_op);
        exp_addr_q.push_back(addr);
        exp_dec_q.push_back({word, exp_op});
        for (int i = 0; i < delay; i++) begin
            imem_ack   = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            @(negedge clk);
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, addr);
            chk("wait_valid", {31'd0, instr_valid}, 32'd0);
            @(posedge clk); #1;
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        chk("pc_plus4", pc_plus4, addr + 32'd4);
        @(posedge clk); #1;
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
    endtask

    // Caller is 1 time unit after a rising edge with the DUT in EXEC.
    task automatic retire_instr(input logic br, input logic z, input logic j,
                                input logic [31:0] imm, input int stalls,
                                input logic [31:0] cur_pc, input logic [31:0] cur_word);
        branch  = br;
        zero    = z;
        jump    = j;
        imm_ext = imm;
        for (int i = 0; i < stalls; i++) begin
            retire     = 1'b1;
            stall      = 1'b1;
            imem_ack   = 1'b1;
            imem_rdata = 32'hFFFF_FFFF;
            @(negedge clk);
            chk("stall_pc", pc, cur_pc);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_instr", instr, cur_word);
            @(posedge clk); #1;
        end
        stall    = 1'b0;
        imem_ack = 1'b0;
        retire   = 1'b1;
        @(posedge clk); #1;
        retire  = 1'b0;
        branch  = 1'b0;
        zero    = 1'b0;
        jump    = 1'b0;
        imm_ext = 32'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_pass     = 0;
        n_total    = 0;
        trap_cnt   = 0;
        prev_valid = 1'b0;
        rst        = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        retire     = 1'b0;
        stall      = 1'b0;
        branch     = 1'b0;
        zero       = 1'b0;
        jump       = 1'b0;
        imm_ext    = 32'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pc", pc, 32'h0000_0000);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_trap", {31'd0, trap}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Sequential fetches, first ack one cycle late.
        fetch_instr(32'h0000_0000, 1, W_LOAD, 7'b0000011);
        retire_instr(0, 0, 0, 32'd0, 0, 32'h0000_0000, W_LOAD);
        fetch_instr(32'h0000_0004, 0, W_STORE, 7'b0100011);
        retire_instr(0, 0, 0, 32'd0, 0, 32'h0000_0004, W_STORE);
        fetch_instr(32'h0000_0008, 0, W_ADD, 7'b0110011);
        retire_instr(0, 0, 0, 32'd0, 0, 32'h0000_0008, W_ADD);
        fetch_instr(32'h0000_000C, 0, W_BEQ, 7'b1100011);
        retire_instr(0, 0, 0, 32'd0, 0, 32'h0000_000C, W_BEQ);

        // Taken backward branch from 0x10 by -8.
        fetch_instr(32'h0000_0010, 0, W_BEQ, 7'b1100011);
        retire_instr(1, 1, 0, 32'hFFFF_FFF8, 0, 32'h0000_0010, W_BEQ);
        // Jump +8 back to 0x10.
        fetch_instr(32'h0000_0008, 0, W_JAL, 7'b1101111);
        retire_instr(0, 0, 1, 32'h0000_0008, 0, 32'h0000_0008, W_JAL);
        // Not-taken branch: falls through to 0x14.
        fetch_instr(32'h0000_0010, 0, W_BEQ, 7'b1100011);
        retire_instr(1, 0, 0, 32'hFFFF_FFF8, 0, 32'h0000_0010, W_BEQ);
        // Jump -0x18 to the top of the address space.
        fetch_instr(32'h0000_0014, 0, W_JAL, 7'b1101111);
        retire_instr(0, 0, 1, 32'hFFFF_FFE8, 0, 32'h0000_0014, W_JAL);

        // At 0xFFFF_FFFC: pc_plus4 wraps to 0, jump +8 wraps to 0x4.
        fetch_instr(32'hFFFF_FFFC, 0, W_JAL, 7'b1101111);
        @(negedge clk);
        chk("pc_wrap", pc, 32'hFFFF_FFFC);
        chk("pc_plus4_wrap", pc_plus4, 32'h0000_0000);
        @(posedge clk); #1;
        retire_instr(0, 0, 1, 32'h0000_0008, 0, 32'hFFFF_FFFC, W_JAL);

        // Memory withholds ack for 5 cycles, then 3 stalled retires.
        fetch_instr(32'h0000_0004, 5, W_ADD, 7'b0110011);
        retire_instr(0, 0, 0, 32'd0, 3, 32'h0000_0004, W_ADD);

        // Jump +0x1A from 0x8: target 0x22 is misaligned.
        fetch_instr(32'h0000_0008, 0, W_JAL, 7'b1101111);
        retire_instr(0, 0, 1, 32'h0000_001A, 0, 32'h0000_0008, W_JAL);
        fetch_instr(MIS_ADDR, 1, W_LOAD, 7'b0000011);
        retire_instr(0, 0, 0, 32'd0, 0, MIS_ADDR, W_LOAD);

        // Reset in a FETCH cycle that also carries an ack.
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = W_ADD;
        @(negedge clk);
        chk("rst_fetch_req", {31'd0, imem_req}, 32'd0);
        @(posedge clk); #1;
        rst      = 1'b0;
        imem_ack = 1'b0;
        @(negedge clk);
        chk("post_rst_instr", instr, 32'h0000_0013);
        chk("post_rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("post_rst_pc", pc, 32'h0000_0000);
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);
        @(posedge clk); #1;
        fetch_instr(32'h0000_0000, 0, W_LOAD, 7'b0000011);
        retire_instr(0, 0, 0, 32'd0, 0, 32'h0000_0000, W_LOAD);

        repeat (3) @(posedge clk);
        #1;
        chk("trap_count", trap_cnt, EXP_TRAPS);
        chk("addr_q_empty", exp_addr_q.size(), 32'd0);
        chk("dec_q_empty", exp_dec_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RISC-V core, directly upstream of the main decoder. It holds the program counter, fetches each instruction from instruction memory over a request/acknowledge handshake, and presents the registered instruction and its 7-bit opcode to the decoder. When the downstream stages retire the instruction, it selects the next PC: PC+4, a branch target, or a jump target.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- TRAP_PC, 32'h0000_0100, PC loaded on a misaligned-target trap (used only with the trap feature)
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address; equals pc
- imem_ack  in  1  instruction memory has imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction word
- instr  out  32  registered instruction
- op  out  7  instr[6:0], the decoder input
- instr_valid  out  1  instr is valid for the decode/execute stages
- pc  out  32  address of the current instruction
- pc_plus4  out  32  pc + 4, used as the jal link value
- retire  in  1  downstream has finished the current instruction
- stall  in  1  hold the current instruction; retire is ignored while stall is high
- branch  in  1  decoder branch control
- zero  in  1  ALU zero flag
- jump  in  1  unconditional jump (jal)
- imm_ext  in  32  sign-extended immediate offset
- trap  out  1  one-cycle pulse on a misaligned target (trap feature only)

## Operation
- FSM states: FETCH, EXEC.
- FETCH:
  - imem_req = 1, imem_addr = pc.
  - On imem_ack: instr <= imem_rdata, instr_valid <= 1, go to EXEC.
  - Without imem_ack: stay in FETCH.
- EXEC:
  - imem_req = 0. An imem_ack in this state is ignored.
  - On retire && !stall: pc <= next_pc, instr_valid <= 0, go to FETCH.
  - Otherwise: hold all state.
- Next-PC selection:
  - target = pc + imm_ext, modulo 2^32 (wraps, no overflow flag).
  - take = jump | (branch & zero).
  - next_pc = take ? target : pc + 4. pc + 4 also wraps at 2^32.
- Misaligned target: take == 1 and target[1:0] != 2'b00. Handling depends on the configuration below.
- op is combinational from instr and is valid only while instr_valid = 1.

## Timing
- Reset values of outputs:
  - pc = RESET_PC
  - imem_req = 0
  - instr = 32'h0000_0013 (NOP), instr_valid = 0
  - trap = 0
- rst overrides every other input, in any state. This includes reset mid-fetch: an outstanding request is abandoned, and an ack in the reset cycle is discarded.
- The first cycle after rst deasserts is FETCH with imem_req = 1.
- An ack in the same cycle as the request is accepted; instr_valid = 1 from the next cycle.
- Minimum of 2 cycles per instruction (FETCH with ack, then EXEC with retire).
- imem_addr stays stable while imem_req is high.
- The new pc is visible in the cycle after retire, together with imem_req = 1.
- retire && stall in the same cycle: retire is ignored and nothing changes.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - A misaligned target sets pc <= TRAP_PC instead of the target.
  - trap pulses 1 for exactly the first FETCH cycle.
- FETCH_MISALIGN_TRAP_EN undefined:
  - target[1:0] is forced to 2'b00.
  - The trap port is tied to 0 and the TRAP_PC parameter is unused.

## Structure
- Shared package riscv_pkg holds:
  - opcode constants OP_LOAD 7'b0000011, OP_STORE 7'b0100011, OP_RTYPE 7'b0110011, OP_BRANCH 7'b1100011, OP_JAL 7'b1101111
  - the NOP constant 32'h0000_0013
  - the fetch_state_t enum (FETCH, EXEC)
- One sub-module, next_pc_calc (combinational):
  - inputs: pc, imm_ext, branch, zero, jump
  - outputs: next_pc, misaligned

## Test plan
- Reset, then ack 1 cycle after the request with rdata 32'h0000_2083 -> imem_addr 0, instr_valid = 1, op 7'b0000011; retire -> next fetch at 0x4.
- pc = 0x10, branch = 1, zero = 1, imm_ext = 32'hFFFF_FFF8 -> next pc 0x08. Same with zero = 0 -> 0x14.
- jump = 1, pc = 0xFFFF_FFFC, imm_ext = 8 -> pc wraps to 0x4. pc_plus4 at pc 0xFFFF_FFFC is 0x0.
- Memory withholds ack for 5 cycles -> imem_req held high, imem_addr stable, instr_valid = 0. Then hold stall = 1 with retire = 1 for 3 cycles -> pc unchanged.
- rst asserted in a FETCH cycle that also carries an ack -> instr stays NOP, and the next fetch is at RESET_PC.
- With FETCH_MISALIGN_TRAP_EN, jump to target 0x22 -> trap pulses 1 cycle and the fetch is at 0x100. Without the macro -> fetch at 0x20 and trap stays 0.
